// File: rtl/spi_ws2812_chain.sv
// SPI mode-0 slave that captures a frame of 24-bit GRB words into a pixel buffer and
// replays it as a WS2812B bit stream. Optional per-frame dimming: SPI_WS2812_BRIGHTNESS_EN.
module spi_ws2812_chain #(
   parameter int NUM_LEDS  = 8,
   parameter int BIT_CYC   = 20,
   parameter int T0H_CYC   = 6,
   parameter int T1H_CYC   = 10,
   parameter int RESET_CYC = 1000
) (
   input  logic                            sys_clk,
   input  logic                            sys_rst,
   input  logic                            spi_sclk,
   input  logic                            spi_mosi,
   input  logic                            spi_cs_n,
`ifdef SPI_WS2812_BRIGHTNESS_EN
   input  logic [7:0]                      brightness,
`endif
   output logic                            dout,
   output logic                            busy,
   output logic                            frame_err,
   output logic [$clog2(NUM_LEDS+1)-1:0]   led_count
);

   localparam int CNT_W = $clog2(NUM_LEDS + 1);
   localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int PER_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int LAT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_LATCH = 2'd3
   } tx_state_t;

`ifdef SPI_WS2812_BRIGHTNESS_EN
   function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
      logic [16:0] p;
      p = 17'(c) * (17'(b) + 17'd1);
      return 8'(p >> 8);
   endfunction
`endif

   logic [2:0]        sclk_q;
   logic [2:0]        cs_q;
   logic [1:0]        mosi_q;
   logic [4:0]        bit_cnt_q;
   logic [22:0]       shift_q;
   logic [CNT_W-1:0]  pix_wr_q;
   logic              rx_blk_q;
   logic              commit_pend_q;
   logic [23:0]       buf_q [NUM_LEDS];

   tx_state_t         state_q, state_d;
   logic [PER_W-1:0]  per_q, per_d;
   logic [4:0]        bit_q, bit_d;
   logic [CNT_W-1:0]  pix_rd_q, pix_rd_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  led_count_q, led_count_d;
   logic              frame_err_q, frame_err_d;
   logic              dout_q, dout_d;

   logic              sclk_rise_s;
   logic              cs_fall_s;
   logic              cs_rise_s;
   logic              rx_take_s;
   logic              wr_en_s;
   logic              good_s;
   logic              bad_s;
   logic [23:0]       pix_word_s;
   logic              tx_bit_s;
   logic [PER_W-1:0]  hi_last_s;

   // Input synchronisers; the third stage of sclk/cs is the edge-detect history
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sclk_q <= 3'b000;
         cs_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sclk_q <= {sclk_q[1:0], spi_sclk};
         cs_q   <= {cs_q[1:0], spi_cs_n};
         mosi_q <= {mosi_q[0], spi_mosi};
      end
   end

   // Edge strobes; bits are gated by the previous cs so a same-cycle cs rise keeps the last bit
   always_comb begin
      sclk_rise_s = sclk_q[1] & ~sclk_q[2];
      cs_fall_s   = ~cs_q[1] & cs_q[2];
      cs_rise_s   = cs_q[1] & ~cs_q[2];
      rx_take_s   = sclk_rise_s & ~cs_q[2] & (pix_wr_q != CNT_W'(NUM_LEDS));
      wr_en_s     = rx_take_s & (bit_cnt_q == 5'd23) & ~rx_blk_q;
   end

   // SPI receive counters; commit is judged one cycle after cs rise, after any final write
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bit_cnt_q     <= 5'd0;
         shift_q       <= 23'd0;
         pix_wr_q      <= '0;
         rx_blk_q      <= 1'b0;
         commit_pend_q <= 1'b0;
      end else begin
         commit_pend_q <= cs_rise_s;
         if (cs_fall_s) begin
            bit_cnt_q <= 5'd0;
            pix_wr_q  <= '0;
            rx_blk_q  <= busy_q;
         end else if (rx_take_s) begin
            shift_q <= {shift_q[21:0], mosi_q[1]};
            if (bit_cnt_q == 5'd23) begin
               bit_cnt_q <= 5'd0;
               pix_wr_q  <= pix_wr_q + CNT_W'(1);
            end else begin
               bit_cnt_q <= bit_cnt_q + 5'd1;
            end
         end
      end
   end

   // Pixel buffer write port; contents survive reset
   always_ff @(posedge sys_clk) begin
      if (wr_en_s) begin
         buf_q[pix_wr_q[PIX_W-1:0]] <= {shift_q, mosi_q[1]};
      end
   end

`ifdef SPI_WS2812_BRIGHTNESS_EN
   logic [7:0] bright_q;

   // Brightness is frozen for the whole transmission
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bright_q <= 8'd0;
      end else if (good_s) begin
         bright_q <= brightness;
      end
   end

   // Scaled pixel word currently on the wire
   always_comb begin
      pix_word_s = buf_q[pix_rd_q[PIX_W-1:0]];
      pix_word_s = {scale8(pix_word_s[23:16], bright_q),
                    scale8(pix_word_s[15:8],  bright_q),
                    scale8(pix_word_s[7:0],   bright_q)};
   end
`else
   // Raw pixel word currently on the wire
   always_comb begin
      pix_word_s = buf_q[pix_rd_q[PIX_W-1:0]];
   end
`endif

   // Frame acceptance and current bit high time
   always_comb begin
      good_s    = commit_pend_q & (bit_cnt_q == 5'd0) & (pix_wr_q != '0) & ~busy_q & ~rx_blk_q;
      bad_s     = commit_pend_q & ~good_s;
      tx_bit_s  = pix_word_s[bit_q];
      hi_last_s = tx_bit_s ? PER_W'(T1H_CYC - 1) : PER_W'(T0H_CYC - 1);
   end

   // TX next-state: HIGH/LOW share one period counter so bits abut with no gap
   always_comb begin
      state_d     = state_q;
      per_d       = per_q;
      bit_d       = bit_q;
      pix_rd_d    = pix_rd_q;
      lat_d       = lat_q;
      busy_d      = busy_q;
      led_count_d = led_count_q;
      frame_err_d = bad_s;
      dout_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (good_s) begin
               state_d     = ST_HIGH;
               per_d       = '0;
               bit_d       = 5'd23;
               pix_rd_d    = '0;
               busy_d      = 1'b1;
               led_count_d = pix_wr_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HIGH: begin
            dout_d = 1'b1;
            per_d  = per_q + PER_W'(1);
            if (per_q == hi_last_s) begin
               state_d = ST_LOW;
            end else begin
               state_d = ST_HIGH;
            end
         end
         ST_LOW: begin
            if (per_q == PER_W'(BIT_CYC - 1)) begin
               per_d   = '0;
               state_d = ST_HIGH;
               if (bit_q == 5'd0) begin
                  bit_d = 5'd23;
                  if (pix_rd_q == led_count_q - CNT_W'(1)) begin
                     state_d = ST_LATCH;
                     lat_d   = '0;
                  end else begin
                     pix_rd_d = pix_rd_q + CNT_W'(1);
                  end
               end else begin
                  bit_d = bit_q - 5'd1;
               end
            end else begin
               per_d = per_q + PER_W'(1);
            end
         end
         ST_LATCH: begin
            if (lat_q == LAT_W'(RESET_CYC - 1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // TX state and registered outputs
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         per_q       <= '0;
         bit_q       <= 5'd0;
         pix_rd_q    <= '0;
         lat_q       <= '0;
         busy_q      <= 1'b0;
         led_count_q <= '0;
         frame_err_q <= 1'b0;
         dout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         per_q       <= per_d;
         bit_q       <= bit_d;
         pix_rd_q    <= pix_rd_d;
         lat_q       <= lat_d;
         busy_q      <= busy_d;
         led_count_q <= led_count_d;
         frame_err_q <= frame_err_d;
         dout_q      <= dout_d;
      end
   end

   assign dout      = dout_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign led_count = led_count_q;

endmodule

// File: tb/tb_spi_ws2812_chain.sv
// Bench for spi_ws2812_chain: frame table plus random pixels against a waveform model,
// with hand sequences for busy collision and asynchronous reset.
module tb_spi_ws2812_chain;

   localparam int NL    = 8;
   localparam int BITC  = 20;
   localparam int T0H   = 6;
   localparam int T1H   = 10;
   localparam int RSTC  = 1000;
   localparam int CNT_W = $clog2(NL + 1);

   typedef struct {
      int          nbits;
      logic [23:0] p0;
      logic [23:0] p1;
      logic [23:0] p2;
      bit          rnd;
      bit          exp_err;
      int          exp_cnt;
   } vec_t;

   logic             clk;
   logic             sys_rst;
   logic             spi_sclk;
   logic             spi_mosi;
   logic             spi_cs_n;
   logic             dout;
   logic             busy;
   logic             frame_err;
   logic [CNT_W-1:0] led_count;

   int total;
   int bad;
   int err_cycles;
   int busy_rises;
   bit busy_prev;

   logic [23:0] px_q [$];
   bit          cap_q [$];
   bit          exp_q [$];

   spi_ws2812_chain #(
      .NUM_LEDS(NL), .BIT_CYC(BITC), .T0H_CYC(T0H), .T1H_CYC(T1H), .RESET_CYC(RSTC)
   ) dut (
      .sys_clk(clk),
      .sys_rst(sys_rst),
      .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi),
      .spi_cs_n(spi_cs_n),
`ifdef SPI_WS2812_BRIGHTNESS_EN
      .brightness(8'd255),
`endif
      .dout(dout),
      .busy(busy),
      .frame_err(frame_err),
      .led_count(led_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err === 1'b1) err_cycles++;
      if (busy === 1'b1 && !busy_prev) busy_rises++;
      busy_prev = (busy === 1'b1);
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Shifts nbits out MSB first from px_q; bits past px_q are random
   task automatic send_frame(input int nbits);
      logic [23:0] w;
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i / 24 < px_q.size()) begin
            w = px_q[i / 24];
            spi_mosi = w[23 - (i % 24)];
         end else begin
            spi_mosi = 1'($urandom);
         end
         repeat (4) @(negedge clk);
         spi_sclk = 1'b1;
         repeat (4) @(negedge clk);
         spi_sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic capture();
      int t;
      cap_q.delete();
      t = 0;
      while (busy !== 1'b1 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("busy_rise", {31'd0, busy}, 32'd1);
      if (busy === 1'b1) begin
         while (busy === 1'b1 && t < 40000) begin
            cap_q.push_back(dout);
            @(negedge clk);
            t++;
         end
      end
   endtask

   // Ideal line: one idle cycle, then each bit as a high pulse plus low, then the latch
   task automatic build_expected(input int npix);
      logic [23:0] w;
      int hi;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int k = 0; k < npix; k++) begin
         w = px_q[k];
         for (int b = 23; b >= 0; b--) begin
            hi = w[b] ? T1H : T0H;
            for (int c = 0; c < BITC; c++) exp_q.push_back(c < hi);
         end
      end
      for (int c = 0; c < RSTC - 1; c++) exp_q.push_back(1'b0);
   endtask

   task automatic compare_wave(input string nm);
      int nbad;
      int n;
      nbad = 0;
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      chk({nm, "_len"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < n; i++) begin
         if (cap_q[i] != exp_q[i]) nbad++;
      end
      chk({nm, "_wave_errs"}, nbad, 0);
   endtask

   task automatic good_frame(input string nm, input int nbits, input int exp_cnt);
      int e0;
      int npix;
      e0 = err_cycles;
      fork
         capture();
         send_frame(nbits);
      join
      npix = nbits / 24;
      if (npix > NL) npix = NL;
      build_expected(npix);
      compare_wave(nm);
      chk({nm, "_no_err"}, err_cycles - e0, 0);
      chk({nm, "_led_count"}, led_count, exp_cnt);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int e0;
      int b0;
      int n;
      string nm;
      nm = $sformatf("vec%0d", idx);
      px_q.delete();
      n = (v.nbits + 23) / 24;
      for (int k = 0; k < n; k++) begin
         if (v.rnd || k > 2) px_q.push_back(24'($urandom));
         else if (k == 0)    px_q.push_back(v.p0);
         else if (k == 1)    px_q.push_back(v.p1);
         else                px_q.push_back(v.p2);
      end
      if (v.exp_err) begin
         e0 = err_cycles;
         b0 = busy_rises;
         send_frame(v.nbits);
         repeat (20) @(negedge clk);
         chk({nm, "_err_pulse"}, err_cycles - e0, 1);
         chk({nm, "_no_tx"}, busy_rises - b0, 0);
         chk({nm, "_dout_low"}, {31'd0, dout}, 32'd0);
         chk({nm, "_led_count"}, led_count, v.exp_cnt);
      end else begin
         good_frame(nm, v.nbits, v.exp_cnt);
      end
   endtask

   initial begin
      vec_t vecs [7];
      int   e0;
      int   t;

      vecs[0] = '{nbits: 24,  p0: 24'hFF0000, p1: 24'h0,      p2: 24'h0,      rnd: 1'b0, exp_err: 1'b0, exp_cnt: 1};
      vecs[1] = '{nbits: 72,  p0: 24'h123456, p1: 24'hABCDEF, p2: 24'h000001, rnd: 1'b0, exp_err: 1'b0, exp_cnt: 3};
      vecs[2] = '{nbits: 40,  p0: 24'h0,      p1: 24'h0,      p2: 24'h0,      rnd: 1'b1, exp_err: 1'b1, exp_cnt: 3};
      vecs[3] = '{nbits: 240, p0: 24'h0,      p1: 24'h0,      p2: 24'h0,      rnd: 1'b1, exp_err: 1'b0, exp_cnt: 8};
      vecs[4] = '{nbits: 0,   p0: 24'h0,      p1: 24'h0,      p2: 24'h0,      rnd: 1'b1, exp_err: 1'b1, exp_cnt: 8};
      vecs[5] = '{nbits: 48,  p0: 24'h0,      p1: 24'h0,      p2: 24'h0,      rnd: 1'b1, exp_err: 1'b0, exp_cnt: 2};
      vecs[6] = '{nbits: 23,  p0: 24'h0,      p1: 24'h0,      p2: 24'h0,      rnd: 1'b1, exp_err: 1'b1, exp_cnt: 2};

      total      = 0;
      bad        = 0;
      err_cycles = 0;
      busy_rises = 0;
      busy_prev  = 1'b0;
      sys_rst    = 1'b1;
      spi_sclk   = 1'b0;
      spi_mosi   = 1'b0;
      spi_cs_n   = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_dout", {31'd0, dout}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_led_count", led_count, 0);
      sys_rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // New frame while busy: rejected, old data keeps transmitting
      e0 = err_cycles;
      px_q.delete();
      px_q.push_back(24'h0000FF);
      fork
         capture();
         begin
            send_frame(24);
            t = 0;
            while (busy !== 1'b1 && t < 1000) begin
               @(negedge clk);
               t++;
            end
            repeat (50) @(negedge clk);
            px_q.delete();
            px_q.push_back(24'h00FF00);
            send_frame(24);
         end
      join
      px_q.delete();
      px_q.push_back(24'h0000FF);
      build_expected(1);
      compare_wave("collide");
      chk("collide_err_pulse", err_cycles - e0, 1);
      chk("collide_led_count", led_count, 1);
      px_q.delete();
      px_q.push_back(24'h00FF00);
      good_frame("after_collide", 24, 1);

      // Reset in the middle of a high pulse
      px_q.delete();
      px_q.push_back(24'hFFFFFF);
      send_frame(24);
      t = 0;
      while (dout !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk("pre_rst_dout", {31'd0, dout}, 32'd1);
      #2 sys_rst = 1'b1;
      #1;
      chk("async_rst_dout", {31'd0, dout}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_led_count", led_count, 0);
      @(negedge clk);
      sys_rst = 1'b0;
      repeat (5) @(negedge clk);
      px_q.delete();
      px_q.push_back(24'hA5C33C);
      good_frame("after_rst", 24, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
